// File: rtl/noise_ctrl_pkg.sv
// rtl/noise_ctrl_pkg.sv - shared state encodings, default geometry and width helpers for the noise frame controller
package noise_ctrl_pkg;

  // Controller states; fsm_state exposes this 3-bit encoding directly
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

  // Default frame geometry and pipeline depth
  localparam int DEF_IMG_W    = 512;
  localparam int DEF_IMG_H    = 320;
  localparam int DEF_WIN      = 7;
  localparam int DEF_PIPE_LAT = 19;  // 6 window/state + 3 SL/SM/SR + 10 compute

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_COL_W   = cnt_w(DEF_IMG_W);
  localparam int DEF_ROW_W   = cnt_w(DEF_IMG_H);
  localparam int DEF_DRAIN_W = cnt_w(DEF_PIPE_LAT);

endpackage

// File: rtl/noise_valid_delay.sv
// rtl/noise_valid_delay.sv - free-running single-bit delay line that tracks results through the fixed-latency pipeline
module noise_valid_delay #(
  parameter int DEPTH = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  generate
    if (DEPTH == 1) begin : g_single
      logic sr_q;

      // One-stage delay; cleared on reset so no stale flag survives an abort
      always_ff @(posedge clk) begin
        if (!rst) sr_q <= 1'b0;
        else      sr_q <= din;
      end

      assign dout = sr_q;
    end else begin : g_multi
      logic [DEPTH-1:0] sr_q;

      // Shift every cycle regardless of pixel flow so upstream gaps become bubbles
      always_ff @(posedge clk) begin
        if (!rst) sr_q <= '0;
        else      sr_q <= {sr_q[DEPTH-2:0], din};
      end

      assign dout = sr_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/noise_frame_ctrl.sv
// rtl/noise_frame_ctrl.sv - raster frame sequencer: pixel handshake, col/row tracking, window flag and drain/complete
// Optional: NOISE_FRAME_CTRL_AUTORESTART_EN chains frames back-to-back without start.
module noise_frame_ctrl
  import noise_ctrl_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int WIN      = DEF_WIN,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     pix_en,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic [$clog2(IMG_H)-1:0] row,
  output logic                     win_valid,
  output logic                     res_valid,
  output logic                     busy,
  output logic                     frame_complete,
  output logic [2:0]               fsm_state
);

  localparam int COL_W   = $clog2(IMG_W);
  localparam int ROW_W   = $clog2(IMG_H);
  localparam int DRAIN_W = cnt_w(PIPE_LAT);

  localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0]   COL_FIRST = COL_W'(WIN - 1);
  localparam logic [ROW_W-1:0]   ROW_FIRST = ROW_W'(WIN - 1);
  localparam logic [DRAIN_W-1:0] DRN_LAST  = DRAIN_W'(PIPE_LAT - 1);

  state_t               state_q, state_d;
  logic [COL_W-1:0]     col_q;
  logic [ROW_W-1:0]     row_q;
  logic [DRAIN_W-1:0]   drn_q;
  logic                 col_wrap;
  logic                 last_pix;

  // Handshake is derived from state only, so din_valid never reaches din_ready
  assign pix_en   = din_valid & din_ready;
  assign col_wrap = (col_q == COL_LAST);
  assign last_pix = pix_en & col_wrap & (row_q == ROW_LAST);

  // Window is fully inside once both coordinates have seen WIN-1 earlier pixels
  assign win_valid = pix_en & (row_q >= ROW_FIRST) & (col_q >= COL_FIRST);

  assign col       = col_q;
  assign row       = row_q;
  assign fsm_state = state_q;
  assign busy      = (state_q != ST_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and per-state outputs; start is only honoured from IDLE
  always_comb begin
    state_d        = state_q;
    din_ready      = 1'b0;
    frame_complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        din_ready = 1'b1;
        if (last_pix) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drn_q == DRN_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        frame_complete = 1'b1;
`ifdef NOISE_FRAME_CTRL_AUTORESTART_EN
        state_d = ST_RUN;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Raster coordinates advance only on accepted pixels; drain counter runs while the pipeline empties
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      drn_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          drn_q <= '0;
          if (start) begin
            col_q <= '0;
            row_q <= '0;
          end
        end
        ST_RUN: begin
          drn_q <= '0;
          if (pix_en) begin
            if (col_wrap) begin
              col_q <= '0;
              row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          drn_q <= drn_q + 1'b1;
        end
        ST_DONE: begin
          col_q <= '0;
          row_q <= '0;
          drn_q <= '0;
        end
        default: begin
          col_q <= '0;
          row_q <= '0;
          drn_q <= '0;
        end
      endcase
    end
  end

  noise_valid_delay #(
    .DEPTH (PIPE_LAT)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (win_valid),
    .dout (res_valid)
  );

endmodule

// File: tb/tb_noise_frame_ctrl.sv
// tb/tb_noise_frame_ctrl.sv - directed self-checking bench for noise_frame_ctrl on a 16x12 frame
module tb_noise_frame_ctrl;

  localparam int W   = 16;
  localparam int H   = 12;
  localparam int LAT = 19;
  localparam int NPIX = W * H;                 // 192
  localparam int NWIN = (W - 6) * (H - 6);     // 60

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_ready, pix_en, win_valid, res_valid, busy, frame_complete;
  logic [3:0] col, row;
  logic [2:0] fsm_state;

  always #5 clk = ~clk;

  noise_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .WIN(7), .PIPE_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .din_valid(din_valid),
    .din_ready(din_ready), .pix_en(pix_en), .col(col), .row(row),
    .win_valid(win_valid), .res_valid(res_valid), .busy(busy),
    .frame_complete(frame_complete), .fsm_state(fsm_state)
  );

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int exp_idx = 0;
  int n_pix = 0, n_win = 0, n_res = 0, n_fc = 0;
  int first_pix_cyc = -1, last_pix_cyc = -1, last_res_cyc = -1, fc_cyc = -1, res_at_fc = 0;
  int c0, p0, w0, r0, f0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Observe the current cycle against the raster model
  task automatic sample();
    int ec, er;
    if (!rst) begin
      exp_idx = 0;
    end else begin
      if (pix_en) begin
        ec = exp_idx % W;
        er = exp_idx / W;
        chk("col", col, ec);
        chk("row", row, er);
        chk("win_flag", win_valid, (ec >= 6 && er >= 6) ? 1 : 0);
        n_pix++;
        if (first_pix_cyc < 0) first_pix_cyc = cyc;
        last_pix_cyc = cyc;
        exp_idx = (exp_idx == NPIX - 1) ? 0 : exp_idx + 1;
      end else begin
        chk("win_idle", win_valid, 0);
      end
    end
    if (win_valid) n_win++;
    if (res_valid) begin n_res++; last_res_cyc = cyc; end
    if (frame_complete) begin n_fc++; fc_cyc = cyc; res_at_fc = n_res; end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic snap();
    c0 = cyc; p0 = n_pix; w0 = n_win; r0 = n_res; f0 = n_fc;
    first_pix_cyc = -1;
  endtask

  task automatic run_until_fc(input int budget);
    int fl, b;
    fl = n_fc;
    b = 0;
    while (n_fc == fl && b < budget) begin step(); b++; end
    chk("fc_seen", n_fc - fl, 1);
  endtask

  task automatic do_reset();
    din_valid = 1'b0; start = 1'b0; rst = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic reset_mid(input int at_pix);
    int b;
    snap();
    start = 1'b1; din_valid = 1'b1;
    step();
    start = 1'b0;
    b = 0;
    while (n_pix - p0 < at_pix - 1 && b < 2000) begin step(); b++; end
    chk("rm_reach", n_pix - p0, at_pix - 1);
    rst = 1'b0;
    step();
    chk("rm_state", fsm_state, 0);
    chk("rm_ready", din_ready, 0);
    chk("rm_pix_en", pix_en, 0);
    chk("rm_res", res_valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_fc", frame_complete, 0);
    chk("rm_col", col, 0);
    chk("rm_row", row, 0);
    rst = 1'b1;
    r0 = n_res; f0 = n_fc; p0 = n_pix;
    repeat (40) step();
    chk("rm_no_res", n_res - r0, 0);
    chk("rm_no_fc", n_fc - f0, 0);
    chk("rm_no_pix", n_pix - p0, 0);
    din_valid = 1'b0;
  endtask

  initial begin
    int b, k;

    // Reset state
    step(); step();
    chk("rst_state", fsm_state, 0);
    chk("rst_ready", din_ready, 0);
    chk("rst_pix_en", pix_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", res_valid, 0);
    chk("rst_fc", frame_complete, 0);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    rst = 1'b1;
    step();

    // Contiguous frame, start held in the cycle of the last pixel
    snap();
    start = 1'b1; din_valid = 1'b1;
    step();
    start = 1'b0;
    b = 0;
    while (cyc < c0 + NPIX && b < 1000) begin step(); b++; end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("last_pix_start", fsm_state, 2);
    chk("drain_ready", din_ready, 0);
    run_until_fc(400);
    chk("first_pix_cyc", first_pix_cyc - c0, 1);
    chk("last_pix_cyc", last_pix_cyc - c0, NPIX);
    chk("last_res_cyc", last_res_cyc - c0, NPIX + LAT);
    chk("fc_cyc", fc_cyc - c0, NPIX + LAT + 1);
    chk("win_count", n_win - w0, NWIN);
    chk("res_count", n_res - r0, NWIN);
    chk("res_before_fc", res_at_fc - r0, NWIN);
    chk("pix_count", n_pix - p0, NPIX);
`ifdef NOISE_FRAME_CTRL_AUTORESTART_EN
    chk("ar_state", fsm_state, 1);
    chk("ar_ready", din_ready, 1);
    chk("ar_col", col, 0);
    chk("ar_row", row, 0);
    run_until_fc(600);
    chk("ar_res_count", n_res - r0, 2 * NWIN);
    chk("ar_fc_count", n_fc - f0, 2);
`else
    chk("post_state", fsm_state, 0);
    chk("post_busy", busy, 0);
    chk("post_pix_en", pix_en, 0);
    chk("fc_count", n_fc - f0, 1);
`endif
    do_reset();

    // Stalled input with start pulses during RUN and DRAIN
    snap();
    start = 1'b1; din_valid = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (n_pix - p0 < NPIX && k < 2000) begin
      din_valid = ~din_valid;
      start = (k == 20 || k == 77 || k == 301) ? 1'b1 : 1'b0;
      step();
      k++;
    end
    din_valid = 1'b0; start = 1'b0;
    chk("stall_pix_count", n_pix - p0, NPIX);
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("drain_start_state", fsm_state, 2);
    chk("drain_start_busy", busy, 1);
    run_until_fc(400);
    chk("stall_fc_cyc", fc_cyc - last_pix_cyc, LAT + 1);
    chk("stall_last_res", last_res_cyc - last_pix_cyc, LAT);
    chk("stall_win_count", n_win - w0, NWIN);
    chk("stall_res_count", n_res - r0, NWIN);
    chk("stall_fc_count", n_fc - f0, 1);
    do_reset();

    // Mid-frame resets, one with results still in flight
    reset_mid(100);
    reset_mid(120);

    // Fresh frame after the aborts
    snap();
    start = 1'b1; din_valid = 1'b1;
    step();
    start = 1'b0;
    run_until_fc(400);
    chk("new_win_count", n_win - w0, NWIN);
    chk("new_res_count", n_res - r0, NWIN);
    chk("new_pix_count", n_pix - p0, NPIX);
    chk("new_fc_cyc", fc_cyc - c0, NPIX + LAT + 1);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
